// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the 5-stage RV32I pipeline.
// It tracks the EX/MEM/WB destinations, picks the operand sources, and raises load-use stalls and branch flushes.

module fwd_lane #(
  parameter int RA_W = 5
) (
  input  logic            e_vld,
  input  logic            e_use,
  input  logic [RA_W-1:0] e_rs,
  input  logic            m_vld,
  input  logic            m_rw,
  input  logic [RA_W-1:0] m_rd,
  input  logic            w_vld,
  input  logic            w_rw,
  input  logic [RA_W-1:0] w_rd,
  output logic [1:0]      sel
);
  logic m_hit, w_hit;

  assign m_hit = e_vld & e_use & m_vld & m_rw & (m_rd != '0) & (m_rd == e_rs);
  assign w_hit = e_vld & e_use & w_vld & w_rw & (w_rd != '0) & (w_rd == e_rs);

  // MEM holds the younger producer, so it wins over WB
  always_comb begin
    sel = 2'b00;
    if (m_hit)      sel = 2'b10;
    else if (w_hit) sel = 2'b01;
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_br_taken,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_fd,
  output logic             flush_d,
  output logic             flush_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            regwrite;
  } dst_t;

  logic [STAGES:0]           vld_pipe;  // [0]=EX, [1]=MEM, [2]=WB
  logic [1:0][RA_W-1:0]      e_rs;
  logic [1:0]                e_use;
  logic                      e_mr;
  dst_t                      e_d, m_d, w_d;
  logic [1:0][1:0]           sel;
  logic                      lu;
  logic [1:0][RA_W-1:0]      id_rs;
  logic [1:0]                id_use;

  assign id_rs  = {id_rs2, id_rs1};
  assign id_use = {id_use_rs2, id_use_rs1};

  for (genvar l = 0; l < 2; l++) begin : g_lane
    fwd_lane #(.RA_W(RA_W)) u_lane (
      .e_vld (vld_pipe[0]),
      .e_use (e_use[l]),
      .e_rs  (e_rs[l]),
      .m_vld (vld_pipe[1]),
      .m_rw  (m_d.regwrite),
      .m_rd  (m_d.rd),
      .w_vld (vld_pipe[2]),
      .w_rw  (w_d.regwrite),
      .w_rd  (w_d.rd),
      .sel   (sel[l])
    );
  end

  assign fwd_a_sel = sel[0];
  assign fwd_b_sel = sel[1];

  assign lu = id_valid & vld_pipe[0] & e_mr & e_d.regwrite & (e_d.rd != '0) &
              ((id_use[0] & (id_rs[0] == e_d.rd)) | (id_use[1] & (id_rs[1] == e_d.rd)));

  // a taken branch discards the ID instruction, so it cancels any pending stall
  assign stall_fd = lu & ~ex_br_taken;
  assign flush_e  = lu | ex_br_taken;
  assign flush_d  = ex_br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      e_rs      <= '0;
      e_use     <= '0;
      e_mr      <= 1'b0;
      e_d       <= '0;
      m_d       <= '0;
      w_d       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], id_valid & ~flush_e};
      e_rs        <= id_rs;
      e_use       <= id_use;
      e_mr        <= id_memread;
      e_d.rd      <= id_rd;
      e_d.regwrite <= id_regwrite;
      m_d         <= e_d;
      w_d         <= m_d;
      if (stall_fd && !(&stall_cnt))   stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (ex_br_taken && !(&flush_cnt)) flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule
